// File: rtl/interrupt_controller.sv
// Eight-line edge-triggered interrupt controller: synchronizes raw IRQ lines, records rising edges
// as pending, and latches the highest-priority unmasked request into a vector for the sequencer.
module interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       _arst,
    input  logic [7:0] irq_in,
    input  logic [7:0] z_bus,
    input  logic       ctrl_irq_masks_wrt,
    input  logic       ctrl_int_vector_wrt,
    input  logic       ctrl_int_ack,
    input  logic       ctrl_clear_all_ints,
    output logic       int_pending,
    output logic [7:0] int_vector,
    output logic [7:0] irq_masks,
    output logic [7:0] irq_pending,
    output logic       in_service
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_LATCHED = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sync [SYNC_STAGES];
    logic [7:0] r_edge_prev;
    logic [7:0] r_pending;
    logic [7:0] r_masks;
    logic [2:0] r_irq_num;
    logic [7:0] w_rise;
    logic [7:0] w_active;
    logic [7:0] w_pending_nxt;
    logic [2:0] w_prio_idx;
    logic       w_latch;
    logic       w_ack_fire;

    always_ff @(posedge clk or negedge _arst) begin
        if (!_arst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_edge_prev <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_edge_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Edge flop resets to 0, so a line already high at reset release counts as a new edge.
    assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_edge_prev;
    assign w_active = r_pending & r_masks;

    always_comb begin
        w_prio_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_active[i]) begin
                w_prio_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge _arst) begin
        if (!_arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_ack_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!ctrl_int_vector_wrt && (|w_active)) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_LATCHED;
                end
            end
            ST_LATCHED: begin
                if (ctrl_int_ack) begin
                    w_ack_fire  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (ctrl_clear_all_ints) begin
            w_latch     = 1'b0;
            w_ack_fire  = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    // A new edge on the acknowledged line wins over the ack; clear-all wins over everything.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_ack_fire) begin
            w_pending_nxt[r_irq_num] = 1'b0;
        end
        w_pending_nxt = w_pending_nxt | w_rise;
        if (ctrl_clear_all_ints) begin
            w_pending_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge _arst) begin
        if (!_arst) begin
            r_pending <= '0;
            r_masks   <= '0;
            r_irq_num <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (!ctrl_irq_masks_wrt) begin
                r_masks <= z_bus;
            end
            if (w_latch) begin
                r_irq_num <= w_prio_idx;
            end
        end
    end

    assign int_pending = (r_state == ST_IDLE) && (|w_active);
    assign int_vector  = {3'b000, r_irq_num, 2'b00};
    assign irq_masks   = r_masks;
    assign irq_pending = r_pending;
    assign in_service  = (r_state == ST_LATCHED);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed, table-driven bench for interrupt_controller: one table row per clock cycle,
// plus a hand-written sequence for asynchronous reset in the middle of service.
module tb_interrupt_controller;

    logic       clk;
    logic       _arst;
    logic [7:0] irq_in;
    logic [7:0] z_bus;
    logic       ctrl_irq_masks_wrt;
    logic       ctrl_int_vector_wrt;
    logic       ctrl_int_ack;
    logic       ctrl_clear_all_ints;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_pending;
    logic       in_service;

    int n_checks = 0;
    int n_errors = 0;

    interrupt_controller #(.SYNC_STAGES(2)) dut (
        .clk                (clk),
        ._arst              (_arst),
        .irq_in             (irq_in),
        .z_bus              (z_bus),
        .ctrl_irq_masks_wrt (ctrl_irq_masks_wrt),
        .ctrl_int_vector_wrt(ctrl_int_vector_wrt),
        .ctrl_int_ack       (ctrl_int_ack),
        .ctrl_clear_all_ints(ctrl_clear_all_ints),
        .int_pending        (int_pending),
        .int_vector         (int_vector),
        .irq_masks          (irq_masks),
        .irq_pending        (irq_pending),
        .in_service         (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] z;
        logic       mw_n;
        logic       vw_n;
        logic       ack;
        logic       clr;
        logic [7:0] e_pend;
        logic [7:0] e_mask;
        logic [7:0] e_vec;
        logic       e_intp;
        logic       e_insvc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] irq, input logic [7:0] z, input logic mw_n,
                       input logic vw_n, input logic ack, input logic clr,
                       input logic [7:0] e_pend, input logic [7:0] e_mask,
                       input logic [7:0] e_vec, input logic e_intp, input logic e_insvc);
        vec_t v;
        v.irq = irq; v.z = z; v.mw_n = mw_n; v.vw_n = vw_n; v.ack = ack; v.clr = clr;
        v.e_pend = e_pend; v.e_mask = e_mask; v.e_vec = e_vec;
        v.e_intp = e_intp; v.e_insvc = e_insvc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got 0x%02h, expected 0x%02h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic [7:0] e_pend, input logic [7:0] e_mask,
                           input logic [7:0] e_vec, input logic e_intp, input logic e_insvc);
        chk("irq_pending", row, irq_pending, e_pend);
        chk("irq_masks", row, irq_masks, e_mask);
        chk("int_vector", row, int_vector, e_vec);
        chk("int_pending", row, {7'b0, int_pending}, {7'b0, e_intp});
        chk("in_service", row, {7'b0, in_service}, {7'b0, e_insvc});
    endtask

    task automatic idle_inputs();
        irq_in = 8'h00; z_bus = 8'h00;
        ctrl_irq_masks_wrt = 1'b1; ctrl_int_vector_wrt = 1'b1;
        ctrl_int_ack = 1'b0; ctrl_clear_all_ints = 1'b0;
    endtask

    initial begin
        //   irq   z     mw vw ak cl  pend  mask  vec  ip sv
        // single IRQ3: pending on third posedge, latch, ack
        add(8'h00, 8'hFF, 0, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        add(8'h08, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h08, 8'hFF, 8'h00, 1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h08, 8'hFF, 8'h0C, 0, 1);
        add(8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'hFF, 8'h0C, 0, 0);
        // IRQ5 and IRQ2 together: priority, wrt ignored while latched, second service
        add(8'h24, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h0C, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h0C, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h24, 8'hFF, 8'h0C, 1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h24, 8'hFF, 8'h08, 0, 1);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h24, 8'hFF, 8'h08, 0, 1);
        add(8'h00, 8'h00, 1, 1, 1, 0, 8'h20, 8'hFF, 8'h08, 1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h20, 8'hFF, 8'h14, 0, 1);
        add(8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'hFF, 8'h14, 0, 0);
        // masked IRQ1 stays pending; wrt and ack in IDLE ignored; unmask; mask write while latched
        add(8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 8'h14, 0, 0);
        add(8'h02, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 8'h14, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 8'h14, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h02, 8'h00, 8'h14, 0, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h02, 8'h00, 8'h14, 0, 0);
        add(8'h00, 8'h00, 1, 1, 1, 0, 8'h02, 8'h00, 8'h14, 0, 0);
        add(8'h00, 8'h02, 0, 1, 0, 0, 8'h02, 8'h02, 8'h14, 1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h02, 8'h02, 8'h04, 0, 1);
        add(8'h00, 8'hFF, 0, 1, 0, 0, 8'h02, 8'hFF, 8'h04, 0, 1);
        add(8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'hFF, 8'h04, 0, 0);
        // IRQ4 latched, new IRQ4 edge detected in the ack cycle keeps it pending
        add(8'h10, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h04, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h04, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h10, 8'hFF, 8'h04, 1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h10, 8'hFF, 8'h10, 0, 1);
        add(8'h10, 8'h00, 1, 1, 0, 0, 8'h10, 8'hFF, 8'h10, 0, 1);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h10, 8'hFF, 8'h10, 0, 1);
        add(8'h00, 8'h00, 1, 1, 1, 0, 8'h10, 8'hFF, 8'h10, 1, 0);
        add(8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 8'hFF, 8'h10, 0, 0);
        // pending 0x81, latched IRQ0, clear-all beats a same-cycle edge on bit 6
        add(8'h81, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h10, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h10, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h81, 8'hFF, 8'h10, 1, 0);
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h81, 8'hFF, 8'h00, 0, 1);
        add(8'h40, 8'h00, 1, 1, 0, 0, 8'h81, 8'hFF, 8'h00, 0, 1);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h81, 8'hFF, 8'h00, 0, 1);
        add(8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 8'hFF, 8'h00, 0, 0);
        add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        // relatch IRQ5 path not needed; end with IRQ0 held for the reset sequence
        add(8'h01, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        add(8'h01, 8'h00, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        add(8'h01, 8'h00, 1, 1, 0, 0, 8'h01, 8'hFF, 8'h00, 1, 0);
        add(8'h01, 8'h00, 1, 0, 0, 0, 8'h01, 8'hFF, 8'h00, 0, 1);

        idle_inputs();
        _arst = 1'b0;
        #22;
        chk_all(-1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        _arst = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < tbl.size(); r++) begin
            irq_in              = tbl[r].irq;
            z_bus               = tbl[r].z;
            ctrl_irq_masks_wrt  = tbl[r].mw_n;
            ctrl_int_vector_wrt = tbl[r].vw_n;
            ctrl_int_ack        = tbl[r].ack;
            ctrl_clear_all_ints = tbl[r].clr;
            @(posedge clk); #1;
            chk_all(r, tbl[r].e_pend, tbl[r].e_mask, tbl[r].e_vec, tbl[r].e_intp, tbl[r].e_insvc);
        end

        // Mid-LATCHED asynchronous reset with irq_in held at 0x01.
        idle_inputs();
        irq_in = 8'h01;
        #2;
        _arst = 1'b0;
        #1;
        chk_all(100, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk_all(101, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        _arst = 1'b1;
        @(posedge clk); #1;
        chk_all(102, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all(103, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all(104, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        ctrl_int_vector_wrt = 1'b0;
        @(posedge clk); #1;
        chk_all(105, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        ctrl_int_vector_wrt = 1'b1;
        @(posedge clk); #1;
        chk_all(106, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops per IRQ line (legal range 2..3).
REQ-002 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port _arst  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port irq_in  in  8: raw asynchronous interrupt request lines; bit 0 is highest priority.
REQ-005 SHALL have port z_bus  in  8: data source for mask writes.
REQ-006 SHALL have port ctrl_irq_masks_wrt  in  1: mask register write, active low.
REQ-007 SHALL have port ctrl_int_vector_wrt  in  1: vector latch strobe, active low.
REQ-008 SHALL have port ctrl_int_ack  in  1: acknowledge of the latched IRQ, active high.
REQ-009 SHALL have port ctrl_clear_all_ints  in  1: clear all pending IRQs, active high.
REQ-010 SHALL have port int_pending  out  1: unmasked request present, to the microcode sequencer.
REQ-011 SHALL have port int_vector  out  8: latched vector {3'b000, irq_num[2:0], 2'b00}.
REQ-012 SHALL have port irq_masks  out  8: current mask register (1 = enabled).
REQ-013 SHALL have port irq_pending  out  8: current pending register.
REQ-014 SHALL have port in_service  out  1: high while state is LATCHED.

Function
REQ-015 SHALL pass each irq_in bit through SYNC_STAGES flops, then a rising-edge detector (one extra flop); levels are ignored, only 0->1 edges set pending.
REQ-016 SHALL set pending[i] on the posedge SYNC_STAGES edges after the first posedge that samples irq_in[i] high (default: third posedge counting that sampling edge).
REQ-017 SHALL record edges in pending regardless of mask; masked bits stay pending until cleared.
REQ-018 SHALL load irq_masks from z_bus on any posedge where ctrl_irq_masks_wrt is 0.
REQ-019 SHALL drive int_pending = |(irq_pending & irq_masks) when state is IDLE, else 0; combinational from registers, no added latency.
REQ-020 SHALL implement a two-state FSM: IDLE, LATCHED.
REQ-021 SHALL, in IDLE at a posedge where ctrl_int_vector_wrt is 0 and an unmasked bit is pending, latch the lowest-numbered unmasked pending index into irq_num, update int_vector, and go to LATCHED.
REQ-022 SHALL, in IDLE with ctrl_int_vector_wrt 0 and nothing unmasked pending, keep int_vector unchanged and stay IDLE.
REQ-023 SHALL ignore ctrl_int_vector_wrt in LATCHED; int_vector holds.
REQ-024 SHALL, in LATCHED at a posedge with ctrl_int_ack 1, clear pending[irq_num] and return to IDLE; ctrl_int_ack in IDLE is ignored.
REQ-025 SHALL keep pending[irq_num] set if a new edge on that line is detected in the same cycle as the ack (new edge wins).
REQ-026 SHALL, on ctrl_clear_all_ints 1, clear all pending bits and return to IDLE; clear overrides same-cycle new edges and ack.
REQ-027 SHALL apply mask writes in LATCHED without altering irq_num or int_vector.

Reset
REQ-028 SHALL, while _arst is 0, asynchronously force: sync/edge flops 0, irq_pending 0x00, irq_masks 0x00, int_vector 0x00, irq_num 0, state IDLE, hence int_pending 0 and in_service 0.
REQ-029 SHALL treat a line already high at reset release as a rising edge (pending set SYNC_STAGES+1 posedges later).

Verification
REQ-030 Masks=0xFF, pulse irq_in[3] -> irq_pending=0x08 and int_pending=1 on third posedge; wrt strobe -> int_vector=0x0C, in_service=1, int_pending=0; ack -> irq_pending=0x00, IDLE.
REQ-031 Masks=0xFF, irq_in[5] and irq_in[2] rise together -> wrt latches int_vector=0x08; after ack int_pending=1 again; next wrt gives int_vector=0x14.
REQ-032 Masks=0x00, pulse irq_in[1] -> irq_pending=0x02, int_pending=0; write masks 0x02 -> int_pending=1 next cycle.
REQ-033 In LATCHED on IRQ4, new irq_in[4] edge detected in ack cycle -> irq_pending bit 4 stays 1, state IDLE, int_pending=1.
REQ-034 irq_pending=0x81, ctrl_clear_all_ints=1 with simultaneous new edge on bit 6 -> irq_pending=0x00, IDLE.
REQ-035 Assert _arst low mid-LATCHED with irq_in held 0x01 -> all outputs 0 immediately; after release irq_pending=0x01 on third posedge, int_pending stays 0 (masks 0x00).
